// File: rtl/apb_pkg.sv
// Shared APB link types, the completer FSM state and the word-index helper.
package apb_pkg;

  localparam int unsigned APB_ADDR_WIDTH = 32;
  localparam int unsigned APB_DATA_WIDTH = 32;
  localparam int unsigned APB_WORD_LSB   = 2;
  localparam logic        APB_WRITE      = 1'b1;

  typedef struct packed {
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic                      psel;
    logic [APB_DATA_WIDTH-1:0] pwdata;
    logic                      pstrb;
    logic                      pwrite;
    logic                      penable;
  } apb_req_s;

  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] prdata;
    logic                      pready;
    logic                      pslverr;
  } apb_resp_s;

  typedef enum logic {APB_IDLE, APB_ACCESS} apb_state_e;

  typedef logic [APB_ADDR_WIDTH-APB_WORD_LSB-1:0] apb_word_idx_t;

  function automatic apb_word_idx_t apb_word_idx(input logic [APB_ADDR_WIDTH-1:0] paddr);
    return paddr[APB_ADDR_WIDTH-1:APB_WORD_LSB];
  endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register array behind the APB completer: reg 0 is a constant ID, the rest are R/W.
module apb_reg_bank #(
  parameter int unsigned NUM_REGS = 8,
  parameter logic [31:0] ID_VALUE = 32'hA9B0_0001,
  localparam int unsigned IdxW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [IdxW-1:0]          idx,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic [NUM_REGS*32-1:0]   regs
);

  logic [31:0] mem_q [1:NUM_REGS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (idx == IdxW'(i)) begin
          mem_q[i] <= wdata;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (idx == '0) begin
      rdata = ID_VALUE;
    end
    for (int i = 1; i < NUM_REGS; i++) begin
      if (idx == IdxW'(i)) begin
        rdata = mem_q[i];
      end
    end
  end

  always_comb begin
    regs        = '0;
    regs[31:0]  = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      regs[32*i +: 32] = mem_q[i];
    end
  end

endmodule

// File: rtl/apb_reg_completer.sv
// APB completer with programmable wait states, access decode and PSLVERR reporting.
module apb_reg_completer
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  apb_req_s               apb_req_i,
  output apb_resp_s              apb_resp_o,
  output logic [NUM_REGS*32-1:0] regs_o
);

  localparam int unsigned IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  apb_state_e                state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      strb_q, strb_d;
  logic                      write_q, write_d;

  apb_word_idx_t             word_idx;
  logic                      err;
  logic                      pready;
  logic                      we;
  logic [31:0]               rdata;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= APB_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    write_d = write_q;
    unique case (state_q)
      APB_IDLE: begin
        // PENABLE without a preceding setup phase is not a transfer start.
        if (apb_req_i.psel && !apb_req_i.penable) begin
          addr_d  = apb_req_i.paddr;
          wdata_d = apb_req_i.pwdata;
          strb_d  = apb_req_i.pstrb;
          write_d = apb_req_i.pwrite;
          cnt_d   = 4'(WAIT_STATES);
          state_d = APB_ACCESS;
        end
      end
      APB_ACCESS: begin
        if (apb_req_i.psel && apb_req_i.penable) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = APB_IDLE;
          end
        end else begin
          state_d = APB_IDLE;
        end
      end
      default: state_d = APB_IDLE;
    endcase
  end

  assign word_idx = apb_word_idx(addr_q);
  assign err      = (addr_q[APB_WORD_LSB-1:0] != '0)
                  | (word_idx >= apb_word_idx_t'(NUM_REGS))
                  | ((write_q == APB_WRITE) & (word_idx == '0));

  assign pready = (state_q == APB_ACCESS) & apb_req_i.psel & apb_req_i.penable
                & (cnt_q == '0);
  assign we     = pready & (write_q == APB_WRITE) & !err & strb_q;

  always_comb begin
    apb_resp_o         = '0;
    apb_resp_o.pready  = pready;
    apb_resp_o.pslverr = pready & err;
    if (pready && (write_q != APB_WRITE) && !err) begin
      apb_resp_o.prdata = rdata;
    end
  end

  apb_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_bank (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .we    (we),
    .idx   (word_idx[IdxW-1:0]),
    .wdata (wdata_q),
    .rdata (rdata),
    .regs  (regs_o)
  );

endmodule

// File: tb/tb_apb_reg_completer.sv
// Bench for apb_reg_completer: a zero-wait and a 3-wait instance against a register-file model.
module tb_apb_reg_completer;
  import apb_pkg::*;

  localparam logic [31:0] ID = 32'hA9B0_0001;
  localparam int          NR = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_req_s    req0, req1;
  apb_resp_s   resp0, resp1;
  logic [255:0] regs0, regs1;

  int checks = 0;
  int failures = 0;
  logic [31:0] model [2][NR];

  apb_reg_completer #(.NUM_REGS(NR), .WAIT_STATES(0), .ID_VALUE(ID)) dut0 (
    .PCLK(clk), .PRESETn(rst_n), .apb_req_i(req0), .apb_resp_o(resp0), .regs_o(regs0)
  );
  apb_reg_completer #(.NUM_REGS(NR), .WAIT_STATES(3), .ID_VALUE(ID)) dut3 (
    .PCLK(clk), .PRESETn(rst_n), .apb_req_i(req1), .apb_resp_o(resp1), .regs_o(regs1)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic psel, input logic penable,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic strb, input logic write);
    apb_req_s r;
    r.paddr = addr; r.psel = psel; r.pwdata = wdata;
    r.pstrb = strb; r.pwrite = write; r.penable = penable;
    if (d == 0) req0 = r; else req1 = r;
  endtask

  function automatic apb_resp_s get_resp(input int d);
    return (d == 0) ? resp0 : resp1;
  endfunction

  function automatic logic [255:0] get_regs(input int d);
    return (d == 0) ? regs0 : regs1;
  endfunction

  function automatic logic [255:0] model_flat(input int d);
    logic [255:0] f;
    f = '0;
    f[31:0] = ID;
    for (int i = 1; i < NR; i++) f[32*i +: 32] = model[d][i];
    return f;
  endfunction

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Setup then access; address/data are scrambled during access to prove they are latched.
  task automatic xfer(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic strb, input logic write,
                      output logic [31:0] rdata, output logic slverr,
                      output int waits, output logic done);
    apb_resp_s r;
    rdata = '0; slverr = 1'b0; waits = 0; done = 1'b0;
    @(posedge clk); #1 drive(d, 1'b1, 1'b0, addr, wdata, strb, write);
    @(posedge clk); #1 drive(d, 1'b1, 1'b1, addr ^ 32'h44, ~wdata, strb, write);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      r = get_resp(d);
      if (r.pready) begin
        rdata = r.prdata; slverr = r.pslverr; done = 1'b1;
        break;
      end
      waits++;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_xfer(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic strb, input logic write, input string tag);
    int unsigned idx;
    logic        err;
    logic [31:0] exp_rd, rd;
    logic        sl, done;
    int          waits;
    idx = int'(addr[31:2]);
    err = (addr[1:0] != 2'b00) || (idx >= NR) || (write && idx == 0);
    exp_rd = '0;
    if (!write && !err) exp_rd = (idx == 0) ? ID : model[d][idx];
    xfer(d, addr, wdata, strb, write, rd, sl, waits, done);
    check({tag, "_done"}, done, 1'b1);
    if (done) begin
      check({tag, "_waits"}, waits, ws_of(d));
      check({tag, "_pslverr"}, sl, err);
      check({tag, "_prdata"}, rd, exp_rd);
    end
    if (write && !err && strb) model[d][idx] = wdata;
  endtask

  task automatic idle(input int d);
    @(posedge clk); #1 drive(d, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_regs(input int d, input string tag);
    check(tag, get_regs(d), model_flat(d));
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NR; i++) model[d][i] = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic        done;
    int          n;
    clear_model();
    drive(0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    #8;
    check("rst_regs0", regs0, model_flat(0));
    check("rst_regs3", regs1, model_flat(1));
    check("rst_resp0", resp0, '0);
    check("rst_resp3", resp1, '0);
    #4 rst_n = 1'b1;

    // Zero-wait write then read back
    do_xfer(0, 32'h4, 32'hDEAD_BEEF, 1'b1, 1'b1, "t1_wr");
    idle(0);
    check("t1_reg1", regs0[63:32], 32'hDEAD_BEEF);
    check_regs(0, "t1_regs");
    do_xfer(0, 32'h4, 32'h0, 1'b1, 1'b0, "t1_rd");
    idle(0);

    do_xfer(1, 32'h0, 32'h0, 1'b1, 1'b0, "t2_id");
    idle(1);

    // Error accesses back-to-back
    do_xfer(0, 32'h0, 32'h1111_2222, 1'b1, 1'b1, "t3_wr0");
    do_xfer(0, 32'h20, 32'h0, 1'b1, 1'b0, "t3_rd20");
    do_xfer(0, 32'h6, 32'h3333_4444, 1'b1, 1'b1, "t3_wr6");
    idle(0);
    check_regs(0, "t3_regs");

    do_xfer(0, 32'h8, 32'h1234_5678, 1'b0, 1'b1, "t4_nostrb");
    idle(0);
    check_regs(0, "t4_regs");

    do_xfer(0, 32'hC, 32'h5, 1'b1, 1'b1, "t5_wr");
    do_xfer(0, 32'hC, 32'h0, 1'b1, 1'b0, "t5_rd");
    @(posedge clk); #1 drive(0, 1'b1, 1'b0, 32'h10, 32'hBAD0_0004, 1'b1, 1'b1);
    @(posedge clk); #1 drive(0, 1'b0, 1'b0, 32'h10, 32'hBAD0_0004, 1'b1, 1'b1);
    @(negedge clk);
    check("t5_abort_pready", resp0.pready, 1'b0);
    idle(0);
    check_regs(0, "t5_abort_regs");
    do_xfer(0, 32'h10, 32'hCAFE_F00D, 1'b1, 1'b1, "t5_after");
    idle(0);
    check_regs(0, "t5_after_regs");

    // Abort of a wait-state transfer after one ACCESS cycle
    @(posedge clk); #1 drive(1, 1'b1, 1'b0, 32'h14, 32'hBAD0_0005, 1'b1, 1'b1);
    @(posedge clk); #1 drive(1, 1'b1, 1'b1, 32'h14, 32'hBAD0_0005, 1'b1, 1'b1);
    @(posedge clk); #1 drive(1, 1'b1, 1'b0, 32'h14, 32'hBAD0_0005, 1'b1, 1'b1);
    idle(1);
    check_regs(1, "t5_abort3_regs");

    for (int it = 0; it < 60; it++) begin
      int          d;
      logic [31:0] addr;
      d = int'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 11)) * 32'd4;
      if ($urandom_range(0, 7) == 0) addr = addr | 32'h2;
      do_xfer(d, addr, $urandom, ($urandom_range(0, 5) != 0), $urandom_range(0, 1) == 1,
              "rnd");
      if ($urandom_range(0, 1) == 1) begin
        idle(d);
        check_regs(d, "rnd_regs");
      end
    end
    idle(0);
    idle(1);
    check_regs(0, "rnd_end_regs0");
    check_regs(1, "rnd_end_regs3");

    // Reset asserted on the completion cycle of a wait-state write
    do_xfer(1, 32'h1C, 32'h7777_0001, 1'b1, 1'b1, "t6_seed");
    idle(1);
    @(posedge clk); #1 drive(1, 1'b1, 1'b0, 32'h18, 32'h5A5A_5A5A, 1'b1, 1'b1);
    @(posedge clk); #1 drive(1, 1'b1, 1'b1, 32'h18, 32'h5A5A_5A5A, 1'b1, 1'b1);
    done = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      if (resp1.pready) done = 1'b1;
      n++;
    end
    check("t6_pre_pready", done, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    clear_model();
    check("t6_rst_pready", resp1.pready, 1'b0);
    check("t6_rst_regs3", regs1, model_flat(1));
    check("t6_rst_regs0", regs0, model_flat(0));
    @(negedge clk) rst_n = 1'b1;
    drive(1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    do_xfer(1, 32'hC, 32'h0000_0077, 1'b1, 1'b1, "t6_after_wr");
    do_xfer(1, 32'hC, 32'h0, 1'b1, 1'b0, "t6_after_rd");
    idle(1);
    check_regs(1, "t6_after_regs");
    a = regs1[31:0];
    check("t6_id", a, ID);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
